// File: rtl/quic_dec_ctrl_if.sv
// quic_dec_ctrl_if: command, table and datapath signals of the QUIC decoder sequencer
//   slave  (sequencer): start/width/height/wm_trigger/pix_done in; state, wmidx, pix_en, x, y, wm_step, done, err out
//   master (environment): the mirror image
interface quic_dec_ctrl_if;
  logic        start;
  logic [15:0] width;
  logic [15:0] height;
  logic [15:0] wm_trigger;
  logic        pix_done;
  logic [2:0]  quic_dec_state;
  logic [2:0]  wmidx;
  logic        pix_en;
  logic [15:0] x;
  logic [15:0] y;
  logic        wm_step;
  logic        done;
  logic        err;
  modport slave (
    input  start, width, height, wm_trigger, pix_done,
    output quic_dec_state, wmidx, pix_en, x, y, wm_step, done, err
  );
  modport master (
    output start, width, height, wm_trigger, pix_done,
    input  quic_dec_state, wmidx, pix_en, x, y, wm_step, done, err
  );
endinterface

// File: rtl/quic_dec_ctrl.sv
// quic_dec_ctrl: sequences table clear/load and paces pixel decode, tracking x/y and the wait-mask index
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : start/width/height command, wm_trigger from tables, pix_done from datapath;
//                  quic_dec_state, wmidx, pix_en, x, y, wm_step, done, err outputs
module quic_dec_ctrl #(
  parameter int WMIMAX = 7
) (
  input  logic           clk,
  input  logic           reset_n,
  quic_dec_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE = 3'd0, SET = 3'd1, INIT = 3'd2, LOAD = 3'd3, RUN = 3'd4, DONE = 3'd5
  } state_t;
  localparam logic [2:0] WMAX = 3'(WMIMAX);
  state_t      r_state, w_next;
  logic [15:0] r_width, r_height, r_x, r_y, r_wmileft;
  logic [2:0]  r_wmidx;
  logic        r_reload, r_wm_step, r_err;
  logic        w_start_ok, w_pix_en, w_acc, w_row_end, w_last, w_can_step, w_exhaust;
  logic [15:0] w_trig;
  assign w_start_ok = bus.start && (bus.width != 16'd0) && (bus.height != 16'd0);
  assign w_pix_en   = (r_state == RUN) && !r_reload;
  assign w_acc      = bus.pix_done && w_pix_en;
  assign w_row_end  = r_x == r_width - 16'd1;
  assign w_last     = w_acc && w_row_end && (r_y == r_height - 16'd1);
  assign w_can_step = r_wmidx < WMAX;
  assign w_exhaust  = w_acc && (r_wmileft <= 16'd1) && w_can_step;
  // a zero budget would never exhaust by counting down, so it is loaded as 1
  assign w_trig     = (bus.wm_trigger == 16'd0) ? 16'd1 : bus.wm_trigger;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_start_ok ? SET : IDLE;
      SET:     w_next = INIT;
      INIT:    w_next = LOAD;
      LOAD:    w_next = RUN;
      RUN:     w_next = w_last ? DONE : RUN;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_width   <= '0;
      r_height  <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_wmileft <= '0;
      r_wmidx   <= '0;
      r_reload  <= 1'b0;
      r_wm_step <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_err     <= (r_state == IDLE) && bus.start && !w_start_ok;
      r_wm_step <= w_exhaust;
      if ((r_state == IDLE) && w_start_ok) begin
        r_width  <= bus.width;
        r_height <= bus.height;
      end
      if (r_state == SET) begin
        r_wmidx  <= '0;
        r_x      <= '0;
        r_y      <= '0;
        r_reload <= 1'b0;
      end
      if (r_state == LOAD) r_wmileft <= w_trig;
      // wmidx already points at the next entry, so wm_trigger now shows its budget
      if (r_reload) begin
        r_wmileft <= w_trig;
        r_reload  <= 1'b0;
      end
      if (w_acc) begin
        r_x <= w_row_end ? 16'd0 : r_x + 16'd1;
        r_y <= w_row_end ? r_y + 16'd1 : r_y;
        if (w_can_step) r_wmileft <= r_wmileft - 16'd1;
        if (w_exhaust) begin
          r_wmidx  <= r_wmidx + 3'd1;
          r_reload <= !w_last;
        end
      end
    end
  end
  assign bus.quic_dec_state = r_state;
  assign bus.wmidx          = r_wmidx;
  assign bus.pix_en         = w_pix_en;
  assign bus.x              = r_x;
  assign bus.y              = r_y;
  assign bus.wm_step        = r_wm_step;
  assign bus.done           = r_state == DONE;
  assign bus.err            = r_err;
endmodule

// File: tb/tb_quic_dec_ctrl.sv
// tb_quic_dec_ctrl: vector table, directed corner sequences and randomized frames against a pixel-count model
module tb_quic_dec_ctrl;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] tab [8];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  quic_dec_ctrl_if bus();
  assign bus.wm_trigger = tab[bus.wmidx];
  quic_dec_ctrl #(.WMIMAX(7)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [15:0] w;
    logic [15:0] h;
    logic [2:0]  exp_state;
    logic        exp_err;
  } vec_t;
  vec_t vecs [6];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    bus.start = 1'b0;
    bus.pix_done = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask
  task automatic set_tab(input int t0, t1, t2, t3, t4, t5, t6, t7);
    tab[0] = 16'(t0); tab[1] = 16'(t1); tab[2] = 16'(t2); tab[3] = 16'(t3);
    tab[4] = 16'(t4); tab[5] = 16'(t5); tab[6] = 16'(t6); tab[7] = 16'(t7);
  endtask
  // Model: index k ends once the cumulative (zero-as-one) budget of entries 0..k is consumed;
  // index 7 never ends. Everything else follows from the accepted-pixel count n.
  task automatic run_frame(input int w, input int h, input int gap_pct,
                           input int exp_steps, input int exp_run);
    int bnd [7];
    int cum, n, total, run_cyc, steps, idx;
    logic pen, stp, pd, acc;
    cum = 0;
    for (int k = 0; k < 7; k++) begin
      cum += (tab[k] == 16'd0) ? 1 : int'(tab[k]);
      bnd[k] = cum;
    end
    total = w * h;
    @(negedge clk);
    bus.start = 1'b1;
    bus.width = 16'(w);
    bus.height = 16'(h);
    bus.pix_done = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    chk("state_set", bus.quic_dec_state, 1);
    @(negedge clk);
    chk("state_init", bus.quic_dec_state, 2);
    @(negedge clk);
    chk("state_load", bus.quic_dec_state, 3);
    chk("load_xy", {bus.x, bus.y}, 0);
    chk("load_pix_en", bus.pix_en, 0);
    n = 0; pen = 1'b1; stp = 1'b0; run_cyc = 0; steps = 0;
    do begin
      @(negedge clk);
      idx = 0;
      for (int k = 0; k < 7; k++) if (bnd[k] <= n) idx++;
      chk("run_state", bus.quic_dec_state, 4);
      chk("run_pix_en", bus.pix_en, pen);
      chk("run_x", bus.x, n % w);
      chk("run_y", bus.y, n / w);
      chk("run_wmidx", bus.wmidx, idx);
      chk("run_wm_step", bus.wm_step, stp);
      chk("run_done_err", {bus.done, bus.err}, 0);
      run_cyc++;
      pd = ($urandom_range(99) >= gap_pct);
      bus.pix_done = pd;
      // start with arbitrary geometry while busy must be ignored
      bus.start = ($urandom_range(7) == 0);
      bus.width = 16'($urandom);
      bus.height = 16'($urandom_range(1) == 0 ? 0 : $urandom);
      acc = pd && pen;
      if (acc) n++;
      stp = 1'b0;
      for (int k = 0; k < 7; k++) if (acc && bnd[k] == n) stp = 1'b1;
      if (stp) steps++;
      pen = !(stp && n < total);
    end while (n < total && run_cyc < 20000);
    if (n < total) chk("run_timeout", n, total);
    @(negedge clk);
    bus.start = 1'b0;
    bus.pix_done = 1'b0;
    idx = 0;
    for (int k = 0; k < 7; k++) if (bnd[k] <= total) idx++;
    chk("done_state", bus.quic_dec_state, 5);
    chk("done_pulse", bus.done, 1);
    chk("done_wm_step", bus.wm_step, stp);
    chk("done_wmidx", bus.wmidx, idx);
    chk("done_pix_en", bus.pix_en, 0);
    @(negedge clk);
    chk("idle_state", bus.quic_dec_state, 0);
    chk("idle_done", {bus.done, bus.wm_step}, 0);
    if (exp_steps >= 0) chk("step_count", steps, exp_steps);
    if (exp_run >= 0) chk("run_cycles", run_cyc, exp_run);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.width = 16'd0;
    bus.height = 16'd0;
    bus.pix_done = 1'b0;
    set_tab(110, 550, 900, 800, 550, 400, 350, 250);
    vecs[0] = '{16'd0,     16'd5, 3'd0, 1'b1};
    vecs[1] = '{16'd5,     16'd0, 3'd0, 1'b1};
    vecs[2] = '{16'd0,     16'd0, 3'd0, 1'b1};
    vecs[3] = '{16'd1,     16'd1, 3'd1, 1'b0};
    vecs[4] = '{16'hffff,  16'd1, 3'd1, 1'b0};
    vecs[5] = '{16'd3,     16'd3, 3'd1, 1'b0};
    #1;
    chk("rst_state", bus.quic_dec_state, 0);
    chk("rst_outs", {bus.wmidx, bus.pix_en, bus.x, bus.y, bus.wm_step, bus.done, bus.err}, 0);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.start = 1'b1;
      bus.width = vecs[i].w;
      bus.height = vecs[i].h;
      @(negedge clk);
      bus.start = 1'b0;
      chk($sformatf("vec%0d_state", i), bus.quic_dec_state, vecs[i].exp_state);
      chk($sformatf("vec%0d_err", i), bus.err, vecs[i].exp_err);
      chk($sformatf("vec%0d_pix_en", i), bus.pix_en, 0);
      @(negedge clk);
      chk($sformatf("vec%0d_err_clr", i), bus.err, 0);
      do_reset();
    end
    run_frame(16, 8, 0, 1, 129);
    run_frame(4096, 1, 0, 7, 4103);
    run_frame(3, 3, 40, 0, -1);
    run_frame(110, 1, 0, 1, 110);
    for (int r = 0; r < 6; r++) begin
      set_tab($urandom_range(6), $urandom_range(6), $urandom_range(6), $urandom_range(6),
              $urandom_range(6), $urandom_range(6), $urandom_range(6), $urandom_range(6));
      run_frame($urandom_range(1, 12), $urandom_range(1, 6), $urandom_range(50), -1, -1);
    end
    set_tab(110, 550, 900, 800, 550, 400, 350, 250);
    @(negedge clk);
    bus.start = 1'b1;
    bus.width = 16'd16;
    bus.height = 16'd8;
    @(negedge clk);
    bus.start = 1'b0;
    bus.pix_done = 1'b1;
    for (int c = 0; c < 40 && !(bus.quic_dec_state == 3'd4 && bus.x == 16'd5); c++) @(negedge clk);
    chk("pre_reset_x", bus.x, 5);
    reset_n = 1'b0;
    #1;
    chk("async_rst_state", bus.quic_dec_state, 0);
    chk("async_rst_outs", {bus.wmidx, bus.pix_en, bus.x, bus.y, bus.wm_step, bus.done, bus.err}, 0);
    bus.pix_done = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    run_frame(4, 2, 20, 0, -1);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
